// File: rtl/dvi_tx_pkg.sv
// Shared types and defaults for the DVI TX reset/bring-up sequencer.
package dvi_tx_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MMCM_RST   = 3'd1,
        WAIT_LOCK  = 3'd2,
        BUFR_RST   = 3'd3,
        SERDES_RST = 3'd4,
        SETTLE     = 3'd5,
        RUN        = 3'd6
    } seq_state_e;

    localparam int DEF_MMCM_RST_CYCLES   = 4;
    localparam int DEF_LOCK_TIMEOUT      = 125000;
    localparam int DEF_SERDES_RST_CYCLES = 16;
    localparam int DEF_SETTLE_CYCLES     = 32;

    localparam int RELOCK_CNT_W = 8;
    localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX = '1;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvi_tx_rst_seq_if.sv
// Control/status bundle between the sequencer and the link it brings up.
interface dvi_tx_rst_seq_if;
    import dvi_tx_pkg::*;

    logic                    i_enable;
    logic                    i_mmcm_locked;
    logic                    o_mmcm_rst;
    logic                    o_bufr_rst;
    logic                    o_serdes_rst;
    logic                    o_video_en;
    logic                    o_lock_timeout;
    logic [RELOCK_CNT_W-1:0] o_relock_cnt;

    modport master (
        output i_enable,
        output i_mmcm_locked,
        input  o_mmcm_rst,
        input  o_bufr_rst,
        input  o_serdes_rst,
        input  o_video_en,
        input  o_lock_timeout,
        input  o_relock_cnt
    );

    modport slave (
        input  i_enable,
        input  i_mmcm_locked,
        output o_mmcm_rst,
        output o_bufr_rst,
        output o_serdes_rst,
        output o_video_en,
        output o_lock_timeout,
        output o_relock_cnt
    );

endinterface

// File: rtl/sync_dff.sv
// Multi-flop synchroniser for a single asynchronous level; flops reset to 0.
module sync_dff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/dvi_tx_rst_seq.sv
// Reset and bring-up sequencer for the DVI TX MMCM / BUFR / OSERDES path.
// Re-runs the sequence on lock loss or lock timeout and keeps debug status.
module dvi_tx_rst_seq
    import dvi_tx_pkg::*;
#(
    parameter int MMCM_RST_CYCLES   = DEF_MMCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int SERDES_RST_CYCLES = DEF_SERDES_RST_CYCLES,
    parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    dvi_tx_rst_seq_if.slave  bus
);

    localparam int MAX_CYCLES = max_of4(MMCM_RST_CYCLES, LOCK_TIMEOUT,
                                        SERDES_RST_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    seq_state_e              state;
    seq_state_e              state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    cnt_done;
    logic                    locked_s;

    logic [RELOCK_CNT_W-1:0] relock_cnt;
    logic [RELOCK_CNT_W-1:0] relock_nxt;
    logic                    lock_timeout;
    logic                    timeout_nxt;

    logic                    mmcm_rst_q;
    logic                    bufr_rst_q;
    logic                    serdes_rst_q;
    logic                    video_en_q;
    logic                    mmcm_rst_d;
    logic                    bufr_rst_d;
    logic                    serdes_rst_d;
    logic                    video_en_d;

    sync_dff #(
        .STAGES (2)
    ) lock_sync (
        .clk   (i_clk),
        .rst_n (i_arst_n),
        .d     (bus.i_mmcm_locked),
        .q     (locked_s)
    );

    // The counter holds "cycles remaining minus one" so a state lasts N cycles.
    function automatic logic [CNT_W-1:0] load_value(input seq_state_e s);
        case (s)
            MMCM_RST:   return CNT_W'(MMCM_RST_CYCLES - 1);
            WAIT_LOCK:  return CNT_W'(LOCK_TIMEOUT - 1);
            SERDES_RST: return CNT_W'(SERDES_RST_CYCLES - 1);
            SETTLE:     return CNT_W'(SETTLE_CYCLES - 1);
            default:    return '0;
        endcase
    endfunction

    assign cnt_done = (cnt == '0);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            relock_cnt   <= '0;
            lock_timeout <= 1'b0;
            mmcm_rst_q   <= 1'b1;
            bufr_rst_q   <= 1'b0;
            serdes_rst_q <= 1'b1;
            video_en_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            relock_cnt   <= relock_nxt;
            lock_timeout <= timeout_nxt;
            mmcm_rst_q   <= mmcm_rst_d;
            bufr_rst_q   <= bufr_rst_d;
            serdes_rst_q <= serdes_rst_d;
            video_en_q   <= video_en_d;
        end
    end

    // Disable beats lock loss, lock loss beats timeout, lock beats timeout.
    always_comb begin
        state_nxt   = state;
        relock_nxt  = relock_cnt;
        timeout_nxt = lock_timeout;
        if (!bus.i_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = MMCM_RST;
                end
                MMCM_RST: begin
                    if (cnt_done) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = BUFR_RST;
                    end else if (cnt_done) begin
                        state_nxt   = MMCM_RST;
                        timeout_nxt = 1'b1;
                    end
                end
                BUFR_RST, SERDES_RST, SETTLE, RUN: begin
                    if (!locked_s) begin
                        state_nxt = MMCM_RST;
                        if (relock_cnt != RELOCK_MAX) relock_nxt = relock_cnt + 1'b1;
                    end else if (state == BUFR_RST) begin
                        state_nxt = SERDES_RST;
                    end else if (cnt_done && state == SERDES_RST) begin
                        state_nxt = SETTLE;
                    end else if (cnt_done && state == SETTLE) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        if (state_nxt != state) begin
            cnt_nxt = load_value(state_nxt);
        end else if (cnt_done) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        mmcm_rst_d   = 1'b0;
        bufr_rst_d   = 1'b0;
        serdes_rst_d = 1'b0;
        video_en_d   = 1'b0;
        case (state_nxt)
            IDLE, MMCM_RST: begin
                mmcm_rst_d   = 1'b1;
                serdes_rst_d = 1'b1;
            end
            WAIT_LOCK: begin
                serdes_rst_d = 1'b1;
            end
            BUFR_RST: begin
                bufr_rst_d   = 1'b1;
                serdes_rst_d = 1'b1;
            end
            SERDES_RST: begin
                serdes_rst_d = 1'b1;
            end
            SETTLE: begin
                serdes_rst_d = 1'b0;
            end
            RUN: begin
                video_en_d   = 1'b1;
            end
            default: begin
                mmcm_rst_d   = 1'b1;
                serdes_rst_d = 1'b1;
            end
        endcase
    end

    assign bus.o_mmcm_rst     = mmcm_rst_q;
    assign bus.o_bufr_rst     = bufr_rst_q;
    assign bus.o_serdes_rst   = serdes_rst_q;
    assign bus.o_video_en     = video_en_q;
    assign bus.o_lock_timeout = lock_timeout;
    assign bus.o_relock_cnt   = relock_cnt;

endmodule
